// File: rtl/bt_line_engine_if.sv
// UART handshake bundle for bt_line_engine: receive strobe/byte and transmit request/done.
interface bt_line_engine_if;
  logic       rx_drdy;
  logic [7:0] rx_byte;
  logic       tx_done;
  logic       send;
  logic [7:0] tx_byte;

  // master = UART side, slave = line engine
  modport master (output rx_drdy, output rx_byte, output tx_done, input send, input tx_byte);
  modport slave  (input rx_drdy, input rx_byte, input tx_done, output send, output tx_byte);
endinterface

// File: rtl/bt_line_engine.sv
// Line-oriented UART message engine: assembles TERM-delimited lines, answers CMD_RESET with a banner.
// Optional feature macro BT_ECHO_EN: echo every non-command line back to the UART.
module bt_line_engine #(
  parameter int                      DEPTH      = 8,
  parameter logic [7:0]              TERM       = 8'h0D,
  parameter int                      BANNER_LEN = 3,
  parameter logic [8*BANNER_LEN-1:0] BANNER     = "ABC",
  parameter logic [7:0]              CMD_RESET  = "R",
  localparam int                     LW         = $clog2(DEPTH + 1)
) (
  input  logic                   rx_clk,
  input  logic                   reset,
  bt_line_engine_if.slave        uart,
  output logic [7:0]             leds,
  output logic                   line_valid,
  output logic [LW-1:0]          line_len,
  output logic                   overflow,
  output logic                   tx_busy,
  output logic                   reply_drop
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd2;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

  logic          prev_rx_drdy_q, prev_rx_drdy_d;
  logic          prev_tx_done_q, prev_tx_done_d;
  logic [7:0]    leds_q, leds_d;
  logic [LW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          line_valid_q, line_valid_d;
  logic [LW-1:0] line_len_q, line_len_d;
  logic          reply_drop_q, reply_drop_d;
  logic          req_q, req_d;
  logic [1:0]    state_q, state_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          send_q, send_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_busy_q, tx_busy_d;

  logic          accept, is_term, is_cmd, want_reply, busy, issue;
  logic [7:0]    byte0;
  logic [LW-1:0] reply_last;
  logic [LW-1:0] rd_idx;
  logic [7:0]    rd_byte;

  function automatic logic [7:0] banner_byte(input int i);
    logic [7:0] b;
    b = TERM;
    for (int k = 0; k < BANNER_LEN; k++)
      if (i == k) b = BANNER[8*(BANNER_LEN-1-k) +: 8];
    return b;
  endfunction

`ifdef BT_ECHO_EN
  logic [7:0]    line_buf_q [DEPTH];
  logic [7:0]    line_buf_d [DEPTH];
  logic [7:0]    tx_buf_q   [DEPTH+1];
  logic [7:0]    tx_buf_d   [DEPTH+1];
  logic [LW-1:0] last_q, last_d;

  assign byte0      = line_buf_q[0];
  assign reply_last = last_q;
  assign want_reply = accept & is_term;

  always_comb begin
    rd_byte = TERM;
    for (int i = 0; i <= DEPTH; i++)
      if (rd_idx == LW'(i)) rd_byte = tx_buf_q[i];
  end
`else
  logic [7:0] first_q, first_d;

  assign byte0      = first_q;
  assign reply_last = LW'(BANNER_LEN);
  assign want_reply = accept & is_term & is_cmd;
  assign rd_byte    = banner_byte(int'(rd_idx));
`endif

  assign accept  = uart.rx_drdy & ~prev_rx_drdy_q;
  assign is_term = (uart.rx_byte == TERM);
  assign is_cmd  = (count_q != '0) && (byte0 == CMD_RESET);
  // A request already latched but not yet taken by the FSM counts as busy.
  assign busy    = tx_busy_q | req_q;
  assign issue   = want_reply & ~busy;
  assign rd_idx  = (state_q == ST_IDLE) ? '0 : idx_q + 1'b1;

  // Receive side: byte capture, line assembly and reply decision.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    prev_rx_drdy_d = uart.rx_drdy;
    leds_d         = leds_q;
    count_d        = count_q;
    overflow_d     = overflow_q & ~line_valid_q;
    line_len_d     = line_len_q;
    line_valid_d   = 1'b0;
    reply_drop_d   = 1'b0;
    req_d          = 1'b0;
`ifdef BT_ECHO_EN
    line_buf_d     = line_buf_q;
    tx_buf_d       = tx_buf_q;
    last_d         = last_q;
`else
    first_d        = first_q;
`endif
    if (accept) begin
      leds_d = uart.rx_byte;
      if (is_term) begin
        line_len_d   = count_q;
        line_valid_d = 1'b1;
        count_d      = '0;
        req_d        = issue;
        reply_drop_d = want_reply & busy;
`ifdef BT_ECHO_EN
        if (issue) begin
          last_d = is_cmd ? LW'(BANNER_LEN) : count_q;
          for (int i = 0; i < DEPTH; i++)
            tx_buf_d[i] = is_cmd ? banner_byte(i)
                                 : ((LW'(i) < count_q) ? line_buf_q[i] : TERM);
          tx_buf_d[DEPTH] = TERM;
        end
`endif
      end else if (count_q == LW'(DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
`ifdef BT_ECHO_EN
        for (int i = 0; i < DEPTH; i++)
          if (count_q == LW'(i)) line_buf_d[i] = uart.rx_byte;
`else
        if (count_q == '0) first_d = uart.rx_byte;
`endif
        count_d = count_q + 1'b1;
      end
    end
  end

  // Transmit side: one byte per send/tx_done handshake, idx runs 0..reply_last.
  always_comb begin
    prev_tx_done_d = uart.tx_done;
    state_d        = state_q;
    idx_d          = idx_q;
    send_d         = send_q;
    tx_byte_d      = tx_byte_q;
    tx_busy_d      = tx_busy_q;
    case (state_q)
      ST_IDLE: begin
        if (req_q) begin
          idx_d     = '0;
          tx_busy_d = 1'b1;
          send_d    = 1'b1;
          tx_byte_d = rd_byte;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!uart.tx_done) begin
          send_d  = 1'b0;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (uart.tx_done && !prev_tx_done_q) state_d = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == reply_last) begin
          tx_busy_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          send_d    = 1'b1;
          tx_byte_d = rd_byte;
          state_d   = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      prev_rx_drdy_q <= 1'b0;
      prev_tx_done_q <= 1'b0;
      leds_q         <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      line_valid_q   <= 1'b0;
      line_len_q     <= '0;
      reply_drop_q   <= 1'b0;
      req_q          <= 1'b0;
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      send_q         <= 1'b0;
      tx_byte_q      <= '0;
      tx_busy_q      <= 1'b0;
`ifdef BT_ECHO_EN
      // NOTE: the byte buffers are cleared on reset too, so no stale line survives into a reply.
      line_buf_q     <= '{default: '0};
      tx_buf_q       <= '{default: '0};
      last_q         <= '0;
`else
      first_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      prev_rx_drdy_q <= prev_rx_drdy_d;
      prev_tx_done_q <= prev_tx_done_d;
      leds_q         <= leds_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      line_valid_q   <= line_valid_d;
      line_len_q     <= line_len_d;
      reply_drop_q   <= reply_drop_d;
      req_q          <= req_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      send_q         <= send_d;
      tx_byte_q      <= tx_byte_d;
      tx_busy_q      <= tx_busy_d;
`ifdef BT_ECHO_EN
      line_buf_q     <= line_buf_d;
      tx_buf_q       <= tx_buf_d;
      last_q         <= last_d;
`else
      first_q        <= first_d;
`endif
    end
  end

  assign uart.send    = send_q;
  assign uart.tx_byte = tx_byte_q;
  assign leds         = leds_q;
  assign line_valid   = line_valid_q;
  assign line_len     = line_len_q;
  assign overflow     = overflow_q;
  assign tx_busy      = tx_busy_q;
  assign reply_drop   = reply_drop_q;

endmodule

// File: tb/tb_bt_line_engine.sv
// Randomised scoreboard bench for bt_line_engine: a line-level reference model predicts line
// events and the UART byte stream; independent monitors pop and compare.
module tb_bt_line_engine;
  localparam int          DEPTH      = 8;
  localparam logic [7:0]  TERM       = 8'h0D;
  localparam int          BANNER_LEN = 3;
  localparam logic [23:0] BANNER     = "ABC";
  localparam logic [7:0]  CMD        = "R";
  localparam int          LW         = $clog2(DEPTH + 1);
`ifdef BT_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  typedef struct {
    int len;
    bit ovf;
    bit drop;
  } line_exp_t;

  logic          rx_clk;
  logic          reset;
  logic [7:0]    leds;
  logic          line_valid;
  logic [LW-1:0] line_len;
  logic          overflow;
  logic          tx_busy;
  logic          reply_drop;

  bt_line_engine_if uif ();

  bt_line_engine #(
    .DEPTH(DEPTH), .TERM(TERM), .BANNER_LEN(BANNER_LEN), .BANNER(BANNER), .CMD_RESET(CMD)
  ) dut (
    .rx_clk(rx_clk), .reset(reset), .uart(uif), .leds(leds), .line_valid(line_valid),
    .line_len(line_len), .overflow(overflow), .tx_busy(tx_busy), .reply_drop(reply_drop)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  int checks = 0;
  int errors = 0;
  int ust;
  int tx_count;

  line_exp_t  exp_line[$];
  logic [7:0] exp_tx[$];
  logic [7:0] line_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string act, input string req);
    checks++;
    errors++;
    $display("FAIL %s: got %s, required %s", name, act, req);
  endtask

  // Reference model: one call per accepted byte; returns 1 when a reply starts.
  function automatic bit model_accept(input logic [7:0] b);
    int n, stored;
    bit ovf, cmd, reply, busy;
    logic [8*BANNER_LEN-1:0] bn;
    if (b != TERM) begin
      line_q.push_back(b);
      return 1'b0;
    end
    bn     = BANNER;
    n      = line_q.size();
    stored = (n > DEPTH) ? DEPTH : n;
    ovf    = (n > DEPTH);
    cmd    = (n >= 1) && (line_q[0] == CMD);
    reply  = cmd || ECHO;
    busy   = (exp_tx.size() != 0);
    exp_line.push_back('{stored, ovf, reply && busy});
    if (reply && !busy) begin
      if (cmd) for (int k = 0; k < BANNER_LEN; k++) exp_tx.push_back(bn[8*(BANNER_LEN-1-k) +: 8]);
      else     for (int k = 0; k < stored; k++)     exp_tx.push_back(line_q[k]);
      exp_tx.push_back(TERM);
    end
    line_q.delete();
    return reply && !busy;
  endfunction

  // UART transmitter model: takes send, drops tx_done, waits for send to clear, then idles again.
  initial begin
    int dly, guard;
    logic [7:0] e;
    uif.tx_done = 1'b1;
    ust = 0;
    tx_count = 0;
    forever begin
      @(negedge rx_clk);
      if (!reset) begin
        ust = 0;
        uif.tx_done = 1'b1;
        continue;
      end
      case (ust)
        0: if (uif.send) begin
             if (exp_tx.size() == 0) fail("unexpected_send", $sformatf("byte 0x%0h", uif.tx_byte), "no send");
             else begin
               e = exp_tx.pop_front();
               check("tx_byte", uif.tx_byte, e);
             end
             tx_count++;
             dly = $urandom_range(0, 3);
             ust = 1;
           end
        1: if (dly == 0) begin uif.tx_done = 1'b0; guard = 0; ust = 2; end
           else dly--;
        2: if (!uif.send) begin dly = $urandom_range(4, 10); ust = 3; end
           else if (++guard > 4) begin fail("send_release", "send held", "send low"); dly = 4; ust = 3; end
        3: if (dly == 0) begin uif.tx_done = 1'b1; ust = 0; end
           else dly--;
        default: ust = 0;
      endcase
    end
  end

  // Line monitor: compares each line_valid pulse with the next predicted line event.
  initial begin
    bit chk_ovf;
    line_exp_t e;
    chk_ovf = 1'b0;
    forever begin
      @(negedge rx_clk);
      if (!reset) begin
        chk_ovf = 1'b0;
        continue;
      end
      if (chk_ovf) begin
        check("overflow_clear", overflow, 0);
        chk_ovf = 1'b0;
      end
      if (line_valid) begin
        if (exp_line.size() == 0) fail("line_valid", "pulse", "no pulse");
        else begin
          e = exp_line.pop_front();
          check("line_len", line_len, e.len);
          check("line_overflow", overflow, e.ovf);
          check("reply_drop", reply_drop, e.drop);
          chk_ovf = 1'b1;
        end
      end else if (reply_drop) begin
        fail("reply_drop_stray", "pulse", "no pulse without line_valid");
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    bit issued;
    @(negedge rx_clk);
    uif.rx_drdy = 1'b1;
    uif.rx_byte = b;
    issued = model_accept(b);
    @(negedge rx_clk);
    check("leds", leds, b);
    if (issued) begin
      @(negedge rx_clk);
      check("send_rise", uif.send, 1);
    end
    repeat (hold - 1 - int'(issued)) @(negedge rx_clk);
    uif.rx_drdy = 1'b0;
    uif.rx_byte = 8'($urandom);
    repeat (gap) @(negedge rx_clk);
  endtask

  task automatic send_line(input logic [7:0] bytes[$]);
    foreach (bytes[k]) send_byte(bytes[k], $urandom_range(1, 3), $urandom_range(0, 2));
    send_byte(TERM, $urandom_range(1, 3), $urandom_range(0, 2));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || ust != 0 || !uif.tx_done) && n < 3000) begin
      @(negedge rx_clk);
      n++;
    end
    repeat (4) @(negedge rx_clk);
    if (n >= 3000) fail("drain_timeout", "reply pending", "reply complete");
    check("tx_busy_idle", tx_busy, 0);
    check("send_idle", uif.send, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int len, n, base;

    reset       = 1'b0;
    uif.rx_drdy = 1'b0;
    uif.rx_byte = 8'h00;
    repeat (3) @(negedge rx_clk);
    check("rst_send", uif.send, 0);
    check("rst_tx_byte", uif.tx_byte, 0);
    check("rst_leds", leds, 0);
    check("rst_line_valid", line_valid, 0);
    check("rst_line_len", line_len, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_reply_drop", reply_drop, 0);
    reset = 1'b1;
    repeat (2) @(negedge rx_clk);

    // Banner command
    send_byte(CMD, 1, 1);
    send_byte(TERM, 1, 1);
    drain();
    check("leds_term", leds, TERM);

    // Plain line (echoed only with the echo build)
    q = {8'h68, 8'h69};
    send_line(q);
    drain();

    // Overflow: ten digits into an eight-byte buffer
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(8'h30 + i), 1, 1);
      check("overflow_flag", overflow, (i >= DEPTH));
    end
    send_byte(TERM, 1, 1);
    drain();

    // Second command while the banner is in flight gets dropped
    base = tx_count;
    send_byte(CMD, 1, 1);
    send_byte(TERM, 1, 1);
    send_byte(CMD, 1, 1);
    send_byte(TERM, 1, 1);
    drain();
    check("drop_tx_bytes", tx_count - base, BANNER_LEN + 1);

    // rx_drdy held high for several cycles: one acceptance per rising edge
    send_byte(8'h78, 5, 1);
    send_byte(8'h79, 5, 2);
    send_byte(TERM, 5, 1);
    drain();

    // Reset while the engine waits for the UART to finish a byte
    send_byte(CMD, 1, 1);
    send_byte(TERM, 1, 1);
    n = 0;
    while (ust != 3 && n < 200) begin
      @(negedge rx_clk);
      n++;
    end
    if (n >= 200) fail("wait_low_timeout", "no byte in flight", "byte in flight");
    #2 reset = 1'b0;
    #1;
    check("midrst_send", uif.send, 0);
    check("midrst_tx_busy", tx_busy, 0);
    check("midrst_leds", leds, 0);
    exp_tx.delete();
    exp_line.delete();
    line_q.delete();
    repeat (3) @(negedge rx_clk);
    reset = 1'b1;
    repeat (4) @(negedge rx_clk);
    check("postrst_send", uif.send, 0);
    check("postrst_tx_busy", tx_busy, 0);
    send_byte(CMD, 1, 1);
    send_byte(TERM, 1, 1);
    drain();

    // Random lines, some commands, some overflowing
    for (int l = 0; l < 40; l++) begin
      q.delete();
      len = $urandom_range(0, 11);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == TERM) b = 8'h20;
        if (k == 0 && $urandom_range(0, 3) == 0) b = CMD;
        q.push_back(b);
      end
      send_line(q);
      drain();
    end

    repeat (4) @(negedge rx_clk);
    check("exp_tx_empty", exp_tx.size(), 0);
    check("exp_line_empty", exp_line.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
